data_memory_decoder: RTL and testbench



---
 rtl/data_memory_decoder.sv | 157 +++++++++++++++
 tb/tb_data_memory_decoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_decoder.sv
// -----------------------------------------------------------------------------
// data_memory_decoder
// Data-side address decoder for the pipelined MIPS core. A load or store goes
// either to a 64x32 data RAM (dataadr[7]=0) or to the board I/O registers
// (dataadr[7]=1). The block also drives the 8-digit multiplexed 7-seg display.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   memwrite   store strobe from the core
//   dataadr    byte address; only bits [7:2] are decoded
//   writedata  store data
//   readdata   load data, combinational from address and state
//   BTNL/BTNR  raw push-buttons, synchronized internally
//   SW         raw slide switches, synchronized internally
//   AN         digit enables, active-low, one digit at a time
//   DP         decimal point, active-low, always off
//   A2G        segments a..g on bits [6]..[0], active-low
// -----------------------------------------------------------------------------
module data_memory_decoder #(
   parameter int SCAN_BITS = 18
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        BTNL,
   input  logic        BTNR,
   input  logic [15:0] SW,
   output logic [7:0]  AN,
   output logic        DP,
   output logic [6:0]  A2G
);

   // Active-low hex to 7-segment encoding, a..g on bits [6]..[0].
   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b0000001;
         4'h1:    seg = 7'b1001111;
         4'h2:    seg = 7'b0010010;
         4'h3:    seg = 7'b0000110;
         4'h4:    seg = 7'b1001100;
         4'h5:    seg = 7'b0100100;
         4'h6:    seg = 7'b0100000;
         4'h7:    seg = 7'b0001111;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0000100;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b1100000;
         4'hC:    seg = 7'b0110001;
         4'hD:    seg = 7'b1000010;
         4'hE:    seg = 7'b0110000;
         4'hF:    seg = 7'b0111000;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   logic [31:0]          mem_q [0:63];
   logic [1:0]           btn_meta_q, btn_sync_q;   // bit1 = left, bit0 = right
   logic [15:0]          sw_meta_q, sw_sync_q;
   logic [15:0]          result_q, result_d;
   logic [SCAN_BITS-1:0] scan_q, scan_d;
   logic [7:0]           an_q, an_d;
   logic [6:0]           a2g_q, a2g_d;
   logic [2:0]           digit_s;
   logic [3:0]           nibble_s;
   logic                 result_we_s;
   logic                 unused_s;

   assign unused_s    = ^{dataadr[31:8], dataadr[1:0], writedata[31:16]};
   assign result_we_s = memwrite && (dataadr[7:2] == 6'h23);

   // Next-state for the result register and scan counter.
   always_comb begin
      result_d = result_q;
      if (result_we_s) begin
         result_d = writedata[15:0];
      end else begin
         result_d = result_q;
      end
      scan_d = scan_q + {{(SCAN_BITS-1){1'b0}}, 1'b1};
   end

   // Display decode works on next-state values so the registered AN/A2G line
   // up with the scan counter and synchronizer outputs of the same cycle.
   always_comb begin
      digit_s = scan_d[SCAN_BITS-1 -: 3];
      case (digit_s)
         3'd0:    nibble_s = result_d[3:0];
         3'd1:    nibble_s = result_d[7:4];
         3'd2:    nibble_s = result_d[11:8];
         3'd3:    nibble_s = result_d[15:12];
         3'd4:    nibble_s = sw_meta_q[3:0];
         3'd5:    nibble_s = sw_meta_q[7:4];
         3'd6:    nibble_s = sw_meta_q[11:8];
         3'd7:    nibble_s = sw_meta_q[15:12];
         default: nibble_s = 4'h0;
      endcase
      an_d  = ~(8'h01 << digit_s);
      a2g_d = seg7(nibble_s);
   end

   // I/O state: synchronizers, result register, scan counter, display outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_meta_q <= 2'b00;
         btn_sync_q <= 2'b00;
         sw_meta_q  <= 16'h0000;
         sw_sync_q  <= 16'h0000;
         result_q   <= 16'h0000;
         scan_q     <= '0;
         an_q       <= 8'hFE;
         a2g_q      <= 7'b0000001;
      end else begin
         btn_meta_q <= {BTNL, BTNR};
         btn_sync_q <= btn_meta_q;
         sw_meta_q  <= SW;
         sw_sync_q  <= sw_meta_q;
         result_q   <= result_d;
         scan_q     <= scan_d;
         an_q       <= an_d;
         a2g_q      <= a2g_d;
      end
   end

   // Data RAM write port; contents are never reset and stores during reset are dropped.
   always_ff @(posedge clk) begin
      if (reset && memwrite && !dataadr[7]) begin
         mem_q[dataadr[7:2]] <= writedata;
      end
   end

   // Load data mux; I/O space holes read as zero.
   always_comb begin
      readdata = 32'h0000_0000;
      if (!dataadr[7]) begin
         readdata = mem_q[dataadr[7:2]];
      end else begin
         case (dataadr[6:2])
            5'h00:   readdata = {30'h0, btn_sync_q};
            5'h01:   readdata = {24'h0, sw_sync_q[15:8]};
            5'h02:   readdata = {24'h0, sw_sync_q[7:0]};
            5'h03:   readdata = {16'h0, result_q};
            default: readdata = 32'h0000_0000;
         endcase
      end
   end

   assign AN  = an_q;
   assign A2G = a2g_q;
   assign DP  = 1'b1;

endmodule

// File: tb/tb_data_memory_decoder.sv
module tb_data_memory_decoder;

   logic        clk;
   logic        reset;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        BTNL;
   logic        BTNR;
   logic [15:0] SW;
   logic [7:0]  AN;
   logic        DP;
   logic [6:0]  A2G;

   int errors = 0;
   int checks = 0;

   data_memory_decoder #(.SCAN_BITS(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .memwrite  (memwrite),
      .dataadr   (dataadr),
      .writedata (writedata),
      .readdata  (readdata),
      .BTNL      (BTNL),
      .BTNR      (BTNR),
      .SW        (SW),
      .AN        (AN),
      .DP        (DP),
      .A2G       (A2G)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      #1;
      checks++;
      if (AN !== 8'hFE) begin errors++; $display("FAIL reset_an: got %h want fe", AN); end
      checks++;
      if (A2G !== 7'b0000001) begin errors++; $display("FAIL reset_a2g: got %b want 0000001", A2G); end
      checks++;
      if (DP !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b want 1", DP); end
      dataadr = 32'h8C;
      #1;
      checks++;
      if (readdata !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", readdata); end
      tick();
      reset = 1'b1;
      SW = 16'h1234;
      tick();
      tick();
      dataadr = 32'h84;
      #1;
      checks++;
      if (readdata !== 32'h00000012) begin errors++; $display("FAIL sw_hi: got %h want 00000012", readdata); end
      dataadr = 32'h88;
      #1;
      checks++;
      if (readdata !== 32'h00000034) begin errors++; $display("FAIL sw_lo: got %h want 00000034", readdata); end
   endtask

   task automatic test_ram();
      memwrite = 1'b1; dataadr = 32'h10; writedata = 32'hDEADBEEF;
      tick();
      memwrite = 1'b0;
      #1;
      checks++;
      if (readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_load: got %h want deadbeef", readdata); end
      memwrite = 1'b1; dataadr = 32'h90; writedata = 32'h0BAD_F00D;
      tick();
      memwrite = 1'b0;
      #1;
      checks++;
      if (readdata !== 32'h0) begin errors++; $display("FAIL io_hole_read: got %h want 00000000", readdata); end
      dataadr = 32'h10;
      #1;
      checks++;
      if (readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_uncorrupted: got %h want deadbeef", readdata); end
   endtask

   task automatic test_buttons();
      dataadr = 32'h80;
      BTNR = 1'b1; BTNL = 1'b0;
      tick();
      checks++;
      if (readdata !== 32'h0) begin errors++; $display("FAIL btnr_one_edge: got %h want 00000000", readdata); end
      tick();
      checks++;
      if (readdata !== 32'h1) begin errors++; $display("FAIL btnr_two_edges: got %h want 00000001", readdata); end
      BTNR = 1'b0; BTNL = 1'b1;
      tick();
      checks++;
      if (readdata !== 32'h1) begin errors++; $display("FAIL btnl_one_edge: got %h want 00000001", readdata); end
      tick();
      checks++;
      if (readdata !== 32'h2) begin errors++; $display("FAIL btnl_two_edges: got %h want 00000002", readdata); end
   endtask

   task automatic test_result();
      memwrite = 1'b1; dataadr = 32'h8C; writedata = 32'hFFFF_46AB;
      #1;
      checks++;
      if (readdata !== 32'h0) begin errors++; $display("FAIL result_same_cycle: got %h want 00000000", readdata); end
      tick();
      memwrite = 1'b0;
      #1;
      checks++;
      if (readdata !== 32'h000046AB) begin errors++; $display("FAIL result_read: got %h want 000046ab", readdata); end
   endtask

   task automatic test_scan();
      logic [7:0] an_exp [8];
      logic [6:0] seg_exp [8];
      logic [7:0] prev;
      bit         found;
      an_exp  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
      seg_exp = '{7'b1100000, 7'b0001000, 7'b0100000, 7'b1001100,
                  7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
      found = 1'b0;
      prev  = AN;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (AN === 8'hFE && prev !== 8'hFE) found = 1'b1;
         prev = AN;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL scan_sync: got no digit-0 entry want one within 40 clocks"); end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (AN !== an_exp[i/2]) begin errors++; $display("FAIL scan_an[%0d]: got %h want %h", i, AN, an_exp[i/2]); end
         checks++;
         if (A2G !== seg_exp[i/2]) begin errors++; $display("FAIL scan_a2g[%0d]: got %b want %b", i, A2G, seg_exp[i/2]); end
         checks++;
         if (DP !== 1'b1) begin errors++; $display("FAIL scan_dp[%0d]: got %b want 1", i, DP); end
         tick();
      end
      checks++;
      if (AN !== 8'hFE) begin errors++; $display("FAIL scan_wrap: got %h want fe", AN); end
   endtask

   task automatic test_async_reset();
      dataadr = 32'h8C;
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      checks++;
      if (readdata !== 32'h0) begin errors++; $display("FAIL async_result: got %h want 00000000", readdata); end
      checks++;
      if (AN !== 8'hFE) begin errors++; $display("FAIL async_an: got %h want fe", AN); end
      checks++;
      if (A2G !== 7'b0000001) begin errors++; $display("FAIL async_a2g: got %b want 0000001", A2G); end
      // Stores while reset is held must be lost.
      memwrite = 1'b1; dataadr = 32'h8C; writedata = 32'h0000_1111;
      tick();
      dataadr = 32'h10; writedata = 32'h5555_5555;
      tick();
      memwrite = 1'b0;
      reset = 1'b1;
      #1;
      checks++;
      if (readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_ram_write_lost: got %h want deadbeef", readdata); end
      dataadr = 32'h8C;
      #1;
      checks++;
      if (readdata !== 32'h0) begin errors++; $display("FAIL reset_result_write_lost: got %h want 00000000", readdata); end
   endtask

   initial begin
      reset = 1'b1; memwrite = 1'b0; dataadr = 32'h0; writedata = 32'h0;
      BTNL = 1'b0; BTNR = 1'b0; SW = 16'h0;
      #2;
      test_reset();
      test_ram();
      test_buttons();
      test_result();
      test_scan();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
